// File: rtl/watch_control_sequencer.sv
// Front-end controller for the watch datapath: button conditioning, mode FSM,
// per-mode command strobes and ring arbitration with acknowledge/timeout.
module watch_control_sequencer #(
  parameter int unsigned DEBOUNCE_TICKS     = 2,
  parameter int unsigned LONG_PRESS_TICKS   = 200,
  parameter int unsigned RING_TIMEOUT_TICKS = 6000
) (
  input  logic       clockSignal,
  input  logic       resetN,
  input  logic       modeInput,
  input  logic       startOrStop,
  input  logic       splitOrReset,
  input  logic       timerDone,
  input  logic       alarmMatch,
  output logic [1:0] mode,
  output logic       timerStartPulse,
  output logic       timerStopPulse,
  output logic       timerClearPulse,
  output logic       swToggle,
  output logic       swLapPulse,
  output logic       swResetPulse,
  output logic       loadClockPulse,
  output logic       loadAlarmPulse,
  output logic       alarmEnable,
  output logic       ringSound,
  output logic [1:0] ringSource
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
  localparam int unsigned RING_W = $clog2(RING_TIMEOUT_TICKS + 1);

  localparam logic [1:0] MODE_TIMER     = 2'd0;
  localparam logic [1:0] MODE_STOPWATCH = 2'd1;
  localparam logic [1:0] MODE_CLOCK     = 2'd2;
  localparam logic [1:0] MODE_ALARM     = 2'd3;

  localparam logic [1:0] RING_IDLE  = 2'd0;
  localparam logic [1:0] RING_TIMER = 2'd1;
  localparam logic [1:0] RING_ALARM = 2'd2;

  logic [2:0]        rawButtons;
  logic [2:0]        syncStage1;
  logic [2:0]        syncStage2;
  logic [2:0]        debounced;
  logic [2:0]        debouncedPrev;
  logic [DEB_W-1:0]  debCount [3];
  logic [2:0]        pressNow;
  logic [2:0]        cmdPress;
  logic              modePress;
  logic              startPress;
  logic              splitPress;
  logic              ackPress;
  logic              abandonHold;
  logic              timerRunning;
  logic              holdActive;
  logic              longDone;
  logic [HOLD_W-1:0] holdCount;
  logic [1:0]        ringState;
  logic [1:0]        ringNext;
  logic              ringRestart;
  logic              ringing;
  logic              timeoutHit;
  logic [RING_W-1:0] ringCount;

  assign rawButtons = {splitOrReset, startOrStop, modeInput};

  // Two-flop synchroniser plus consecutive-mismatch debounce per button
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      syncStage1    <= 3'b000;
      syncStage2    <= 3'b000;
      debounced     <= 3'b000;
      debouncedPrev <= 3'b000;
      for (int i = 0; i < 3; i++) debCount[i] <= '0;
    end else begin
      syncStage1    <= rawButtons;
      syncStage2    <= syncStage1;
      debouncedPrev <= debounced;
      for (int i = 0; i < 3; i++) begin
        if (syncStage2[i] != debounced[i]) begin
          if (debCount[i] >= DEB_W'(DEBOUNCE_TICKS - 1)) begin
            debounced[i] <= ~debounced[i];
            debCount[i]  <= '0;
          end else begin
            debCount[i] <= debCount[i] + DEB_W'(1);
          end
        end else begin
          debCount[i] <= '0;
        end
      end
    end
  end

  // A press while ringing only acknowledges the ring and is otherwise dropped
  assign pressNow    = debounced & ~debouncedPrev;
  assign ringing     = (ringState != RING_IDLE);
  assign ackPress    = ringing & (|pressNow);
  assign cmdPress    = pressNow & {3{~ringing}};
  assign modePress   = cmdPress[0];
  assign startPress  = cmdPress[1];
  assign splitPress  = cmdPress[2];
  assign abandonHold = modePress | ackPress;
  assign timeoutHit  = (ringCount >= RING_W'(RING_TIMEOUT_TICKS - 1));

  // Ring arbitration next state; a fresh alarm outranks everything else
  always_comb begin
    ringNext    = ringState;
    ringRestart = 1'b0;
    case (ringState)
      RING_IDLE: begin
        if (alarmMatch && alarmEnable) begin
          ringNext    = RING_ALARM;
          ringRestart = 1'b1;
        end else if (timerDone) begin
          ringNext    = RING_TIMER;
          ringRestart = 1'b1;
        end
      end
      RING_TIMER: begin
        if (alarmMatch && alarmEnable) begin
          ringNext    = RING_ALARM;
          ringRestart = 1'b1;
        end else if (ackPress || timeoutHit) begin
          ringNext = RING_IDLE;
        end
      end
      RING_ALARM: begin
        if (ackPress || timeoutHit) ringNext = RING_IDLE;
      end
      default: ringNext = RING_IDLE;
    endcase
  end

  // Ring state, timeout counter and registered buzzer outputs
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      ringState  <= RING_IDLE;
      ringCount  <= '0;
      ringSound  <= 1'b0;
      ringSource <= 2'd0;
    end else begin
      ringState  <= ringNext;
      ringSound  <= (ringNext != RING_IDLE);
      ringSource <= ringNext;
      if (ringRestart) ringCount <= '0;
      else if (ringing && !timeoutHit) ringCount <= ringCount + RING_W'(1);
    end
  end

  // Mode register, per-mode command strobes and stopwatch hold tracking
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      mode            <= MODE_TIMER;
      timerRunning    <= 1'b0;
      alarmEnable     <= 1'b0;
      timerStartPulse <= 1'b0;
      timerStopPulse  <= 1'b0;
      timerClearPulse <= 1'b0;
      swToggle        <= 1'b0;
      swLapPulse      <= 1'b0;
      swResetPulse    <= 1'b0;
      loadClockPulse  <= 1'b0;
      loadAlarmPulse  <= 1'b0;
      holdActive      <= 1'b0;
      longDone        <= 1'b0;
      holdCount       <= '0;
    end else begin
      timerStartPulse <= 1'b0;
      timerStopPulse  <= 1'b0;
      timerClearPulse <= 1'b0;
      swToggle        <= 1'b0;
      swLapPulse      <= 1'b0;
      swResetPulse    <= 1'b0;
      loadClockPulse  <= 1'b0;
      loadAlarmPulse  <= 1'b0;

      if (modePress) mode <= mode + 2'd1;

      if (startPress) begin
        case (mode)
          MODE_TIMER: begin
            timerStartPulse <= ~timerRunning;
            timerStopPulse  <= timerRunning;
            timerRunning    <= ~timerRunning;
          end
          MODE_STOPWATCH: swToggle <= 1'b1;
          MODE_ALARM: begin
            loadAlarmPulse <= 1'b1;
            alarmEnable    <= 1'b1;
          end
          default: ;
        endcase
      end

      if (splitPress) begin
        case (mode)
          MODE_TIMER: begin
            timerClearPulse <= 1'b1;
            timerRunning    <= 1'b0;
          end
          MODE_STOPWATCH: begin
            holdActive <= 1'b1;
            holdCount  <= HOLD_W'(1);
            longDone   <= 1'b0;
          end
          MODE_CLOCK: loadClockPulse <= 1'b1;
          MODE_ALARM: alarmEnable    <= 1'b0;
          default: ;
        endcase
      end else if (holdActive) begin
        if (abandonHold) begin
          holdActive <= 1'b0;
        end else if (debounced[2]) begin
          if (!longDone) begin
            if (holdCount >= HOLD_W'(LONG_PRESS_TICKS - 1)) begin
              swResetPulse <= 1'b1;
              longDone     <= 1'b1;
              holdCount    <= HOLD_W'(LONG_PRESS_TICKS);
            end else begin
              holdCount <= holdCount + HOLD_W'(1);
            end
          end
        end else begin
          swLapPulse <= ~longDone;
          holdActive <= 1'b0;
        end
      end

      if (timerDone) timerRunning <= 1'b0;
    end
  end

endmodule

// File: tb/tb_watch_control_sequencer.sv
// Randomised bench for watch_control_sequencer against a transaction-level model.
module tb_watch_control_sequencer;

  localparam int DEB       = 2;
  localparam int LONG      = 200;
  localparam int RING      = 6000;
  localparam int PRESS_AT  = 2 + DEB;   // cycle the debounced level rises
  localparam int STROBE_AT = 3 + DEB;   // cycle the registered strobe is visible

  logic       clockSignal = 1'b0;
  logic       resetN = 1'b0;
  logic       modeInput = 1'b0;
  logic       startOrStop = 1'b0;
  logic       splitOrReset = 1'b0;
  logic       timerDone = 1'b0;
  logic       alarmMatch = 1'b0;
  logic [1:0] mode;
  logic       timerStartPulse, timerStopPulse, timerClearPulse;
  logic       swToggle, swLapPulse, swResetPulse;
  logic       loadClockPulse, loadAlarmPulse, alarmEnable, ringSound;
  logic [1:0] ringSource;

  int compareCount = 0;
  int mismatchCount = 0;
  int cycle = 0;

  // reference model state
  int mMode = 0;
  int mRun = 0;
  int mAlarmEn = 0;
  int mSrc = 0;
  int mRingEnd = 0;

  watch_control_sequencer dut (
    .clockSignal(clockSignal), .resetN(resetN), .modeInput(modeInput),
    .startOrStop(startOrStop), .splitOrReset(splitOrReset),
    .timerDone(timerDone), .alarmMatch(alarmMatch), .mode(mode),
    .timerStartPulse(timerStartPulse), .timerStopPulse(timerStopPulse),
    .timerClearPulse(timerClearPulse), .swToggle(swToggle),
    .swLapPulse(swLapPulse), .swResetPulse(swResetPulse),
    .loadClockPulse(loadClockPulse), .loadAlarmPulse(loadAlarmPulse),
    .alarmEnable(alarmEnable), .ringSound(ringSound), .ringSource(ringSource)
  );

  always #5 clockSignal = ~clockSignal;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [13:0] observedVec();
    return {mode, alarmEnable, ringSource, ringSound, loadAlarmPulse, loadClockPulse,
            swResetPulse, swLapPulse, swToggle, timerClearPulse, timerStopPulse, timerStartPulse};
  endfunction

  function automatic logic ringAt(input int t);
    return (mSrc != 0) && (t <= mRingEnd);
  endfunction

  function automatic logic [13:0] expectVec(input int t, input logic [7:0] strobes, input int m, input int a);
    logic       ring;
    logic [1:0] src;
    ring = ringAt(t);
    src  = ring ? 2'(mSrc) : 2'd0;
    return {2'(m), 1'(a), src, ring, strobes};
  endfunction

  task automatic step();
    @(posedge clockSignal);
    #1;
    cycle++;
  endtask

  task automatic setButton(input int btn, input logic v);
    case (btn)
      0:       modeInput = v;
      1:       startOrStop = v;
      default: splitOrReset = v;
    endcase
  endtask

  // Strobe bits: 0 start,1 stop,2 clear,3 toggle,4 lap,5 swReset,6 loadClock,7 loadAlarm
  task automatic pressButton(input int btn, input int hold);
    int         c0, modeBefore, alarmBefore;
    logic [7:0] expPress, expRel, expLong, expNow;
    bit         pressed, acked;
    c0 = cycle;
    modeBefore = mMode;
    alarmBefore = mAlarmEn;
    expPress = 8'h00;
    expRel = 8'h00;
    expLong = 8'h00;
    pressed = (hold >= DEB);
    acked = pressed && ringAt(c0 + PRESS_AT);
    if (acked) begin
      mRingEnd = c0 + PRESS_AT;
    end else if (pressed) begin
      if (btn == 0) begin
        mMode = (mMode + 1) % 4;
      end else if (btn == 1) begin
        if (mMode == 0) begin
          if (mRun == 0) expPress[0] = 1'b1;
          else           expPress[1] = 1'b1;
          mRun = 1 - mRun;
        end else if (mMode == 1) begin
          expPress[3] = 1'b1;
        end else if (mMode == 3) begin
          expPress[7] = 1'b1;
          mAlarmEn = 1;
        end
      end else begin
        if (mMode == 0) begin
          expPress[2] = 1'b1;
          mRun = 0;
        end else if (mMode == 1) begin
          if (hold >= LONG) expLong[5] = 1'b1;
          else              expRel[4] = 1'b1;
        end else if (mMode == 2) begin
          expPress[6] = 1'b1;
        end else begin
          mAlarmEn = 0;
        end
      end
    end
    setButton(btn, 1'b1);
    for (int off = 1; off <= hold + 8; off++) begin
      step();
      expNow = 8'h00;
      if (off == STROBE_AT) expNow = expNow | expPress;
      if (off == hold + STROBE_AT) expNow = expNow | expRel;
      if (off == PRESS_AT + LONG) expNow = expNow | expLong;
      checkValue($sformatf("press b%0d h%0d off%0d", btn, hold, off), 32'(observedVec()),
                 32'(expectVec(cycle, expNow, (off >= STROBE_AT) ? mMode : modeBefore,
                               (off >= STROBE_AT) ? mAlarmEn : alarmBefore)));
      if (off == hold) setButton(btn, 1'b0);
    end
  endtask

  task automatic pulse(input bit td, input bit am);
    int c0;
    bit ringingNow;
    c0 = cycle;
    ringingNow = ringAt(c0);
    if (am && (mAlarmEn != 0) && (!ringingNow || mSrc == 1)) begin
      mSrc = 2;
      mRingEnd = c0 + RING;
    end else if (td && !ringingNow) begin
      mSrc = 1;
      mRingEnd = c0 + RING;
    end
    if (td) mRun = 0;
    timerDone = td;
    alarmMatch = am;
    step();
    timerDone = 1'b0;
    alarmMatch = 1'b0;
    checkValue($sformatf("pulse td%0d am%0d", td, am), 32'(observedVec()),
               32'(expectVec(cycle, 8'h00, mMode, mAlarmEn)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checkValue("idle", 32'(observedVec()), 32'(expectVec(cycle, 8'h00, mMode, mAlarmEn)));
    end
  endtask

  task automatic modelReset();
    mMode = 0;
    mRun = 0;
    mAlarmEn = 0;
    mSrc = 0;
    mRingEnd = 0;
  endtask

  initial begin
    int r, btn, hold;
    #3;
    checkValue("resetState", 32'(observedVec()), 32'd0);
    step();
    step();
    resetN = 1'b1;
    idle(2);

    // timer start then stop, 5-cycle latency
    pressButton(1, 10);
    pressButton(1, 10);
    // glitch on mode button, then a full mode cycle
    pressButton(0, 1);
    for (int i = 0; i < 4; i++) pressButton(0, 6);

    // stopwatch lap / long-press boundaries
    pressButton(0, 5);
    pressButton(2, 50);
    pressButton(2, 300);
    pressButton(2, LONG - 1);
    pressButton(2, LONG);

    // alarm set, ring, acknowledge with mode button
    pressButton(0, 5);
    pressButton(0, 5);
    pressButton(1, 8);
    pulse(1'b0, 1'b1);
    pressButton(0, 6);
    checkValue("ackKeepsMode", 32'(mode), 32'd3);

    // simultaneous requests, alarm wins, then timeout
    pulse(1'b1, 1'b1);
    checkValue("bothSource", 32'(ringSource), 32'd2);
    idle(RING);

    // randomised mix of presses and ring requests
    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        btn = int'($urandom_range(0, 2));
        if ($urandom_range(0, 19) == 0) hold = 1;
        else if (btn == 2 && mMode == 1 && $urandom_range(0, 3) == 0) hold = int'($urandom_range(195, 230));
        else hold = int'($urandom_range(2, 30));
        pressButton(btn, hold);
      end else if (r == 6) begin
        pulse(1'b1, 1'b0);
      end else if (r == 7) begin
        pulse(1'b0, 1'b1);
      end else if (r == 8) begin
        pulse(1'b1, 1'b1);
      end else begin
        idle(int'($urandom_range(1, 20)));
      end
    end

    // async reset while ringing in clock mode
    while (mMode != 2) pressButton(0, 4);
    if (ringAt(cycle)) pressButton(1, 4);
    pulse(1'b1, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    checkValue("asyncReset", 32'(observedVec()), 32'd0);
    checkValue("asyncResetRing", 32'(ringSound), 32'd0);
    step();
    resetN = 1'b1;
    modelReset();
    idle(2);
    pressButton(1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/watch_control_sequencer.md
Name: watch_control_sequencer

Overview:
Front-end controller for the timer/stopwatch/clock/alarm datapath. It synchronises and debounces the three raw buttons, owns the mode state machine, and decodes each press into one-cycle command strobes for the active function. It also arbitrates the timer-done and alarm-match ring requests onto the single ringSound output, with acknowledge and timeout. It runs on the 100 Hz tick clock; every datapath action is a strobe from this block.

Parameters:
DEBOUNCE_TICKS, 2, consecutive stable cycles before a debounced level changes (20 ms)
LONG_PRESS_TICKS, 200, hold length that turns a splitOrReset press into a long press (2 s)
RING_TIMEOUT_TICKS, 6000, cycles after which an unacknowledged ring self-silences (60 s)

Ports:
clockSignal  in  1  100 Hz clock, all state on rising edge
resetN  in  1  asynchronous active-low reset
modeInput  in  1  raw mode button, asynchronous, active-high
startOrStop  in  1  raw start/stop/set button, asynchronous, active-high
splitOrReset  in  1  raw split/reset button, asynchronous, active-high
timerDone  in  1  one-cycle pulse: countdown reached zero
alarmMatch  in  1  one-cycle pulse: time of day equals stored alarm
mode  out  2  0 timer, 1 stopwatch, 2 viewClockAndDate, 3 setAlarm
timerStartPulse  out  1  load inputs and start countdown
timerStopPulse  out  1  pause countdown
timerClearPulse  out  1  clear countdown
swToggle  out  1  stopwatch run/stop toggle
swLapPulse  out  1  capture lap
swResetPulse  out  1  clear stopwatch and laps
loadClockPulse  out  1  load time of day from inputs
loadAlarmPulse  out  1  store alarm time from inputs
alarmEnable  out  1  alarm armed
ringSound  out  1  buzzer drive
ringSource  out  2  0 none, 1 timer, 2 alarm

Behaviour:
- Reset (async, resetN=0): mode=0; alarmEnable=0; ringSound=0; ringSource=0; all strobes 0; synchronisers, debounced levels, and counters 0; internal timerRunning=0.
- Input path per button: 2-flop synchroniser. The debounced level toggles once the synchronised value has differed from it for DEBOUNCE_TICKS consecutive cycles. A mismatch shorter than that resets the count.
- Press = debounced 0->1. Release = debounced 1->0. Each strobe is registered and high exactly one cycle. Latency from a clean raw rise to the strobe = 2 + DEBOUNCE_TICKS + 1 cycles (5 at default).
- Mode press: mode <= mode+1, wrapping 3->0. No other strobe is emitted.
- startOrStop press, decoded by mode:
  - mode 0: if timerRunning=0, timerStartPulse and timerRunning<=1; else timerStopPulse and timerRunning<=0.
  - mode 1: swToggle.
  - mode 2: none.
  - mode 3: loadAlarmPulse and alarmEnable<=1.
- splitOrReset, decoded by mode:
  - mode 0, press: timerClearPulse, timerRunning<=0.
  - mode 1: a hold counter starts at press. When it reaches LONG_PRESS_TICKS, swResetPulse fires once. A release before that fires swLapPulse. A release after a long press emits nothing.
  - mode 2, press: loadClockPulse.
  - mode 3, press: alarmEnable<=0.
- A mode change while splitOrReset is held abandons the hold; its release emits nothing.
- timerDone forces timerRunning<=0.
- Ring FSM states:
  - IDLE: alarmMatch with alarmEnable=1 -> RING_ALARM. Otherwise timerDone -> RING_TIMER. If both arrive in the same cycle, alarm wins and the timer request is dropped.
  - RING_TIMER / RING_ALARM: ringSound=1, ringSource=1 or 2, timeout counter runs. alarmMatch during RING_TIMER pre-empts to RING_ALARM and restarts the counter. timerDone in any ringing state is ignored.
  - Exit to IDLE: any button press (ack), or the counter reaching RING_TIMEOUT_TICKS.
  - A press that acknowledges a ring is consumed: no mode change and no strobe. This includes a pending lap; the hold is abandoned.
  - ringSound and ringSource update on the cycle after the triggering pulse or ack press.
- alarmMatch with alarmEnable=0 is ignored.
- Counter widths: ceil(log2(param+1)). Counters saturate and never wrap.

Test Plan:
- Reset, then a clean startOrStop rise in mode 0 -> timerStartPulse high exactly one cycle, 5 cycles after the rise. A second press -> timerStopPulse.
- A 1-cycle glitch on modeInput -> mode stays 0. Four clean presses -> mode sequence 1,2,3,0.
- Mode 1, splitOrReset held 50 cycles -> one swLapPulse at release. Held 300 cycles -> one swResetPulse at the 200th debounced-high cycle, nothing at release.
- Mode 3: press startOrStop -> loadAlarmPulse, alarmEnable=1. Pulse alarmMatch -> ringSound=1, ringSource=2. Press modeInput -> ringSound=0, mode still 3.
- timerDone and alarmMatch in the same cycle with alarmEnable=1 -> ringSource=2. With no ack, ringSound drops after 6000 cycles.
- Assert resetN low while ringing in mode 2 -> ringSound=0, mode=0, alarmEnable=0, with no clock edge required.
